// File: rtl/serial_multi_read_buffer_pkg.sv
// Shared definitions for the multi-lane serial read buffer.
//   ST_IDLE / ST_READ : FSM state encodings
//   cnt_width()       : width needed to hold a bit count 0..buf_size
package serial_multi_read_buffer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  function automatic int cnt_width(input int buf_size);
    return $clog2(buf_size + 1);
  endfunction

endpackage

// File: rtl/serial_multi_read_buffer_if.sv
// Bus bundle for serial_multi_read_buffer.
//   master : producer/consumer side (drives control, strobe, lanes, ack)
//   slave  : buffer side (drives data_out, data_valid, done_sig, overrun)
interface serial_multi_read_buffer_if
  import serial_multi_read_buffer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int BUF_SIZE = 8,
  parameter int CNT_W    = cnt_width(BUF_SIZE)
);

  logic                       start;
  logic                       stop;
  logic                       cont_mode;
  logic                       lsb_first;
  logic [CNT_W-1:0]           read_count;
  logic                       read_sig;
  logic [NUM_CH-1:0]          in_lines;
  logic [NUM_CH*BUF_SIZE-1:0] data_out;
  logic                       data_valid;
  logic                       data_ack;
  logic                       done_sig;
  logic                       overrun;

  modport master (
    output start, stop, cont_mode, lsb_first, read_count, read_sig, in_lines, data_ack,
    input  data_out, data_valid, done_sig, overrun
  );

  modport slave (
    input  start, stop, cont_mode, lsb_first, read_count, read_sig, in_lines, data_ack,
    output data_out, data_valid, done_sig, overrun
  );

endinterface

// File: rtl/serial_multi_read_buffer_lane.sv
// One lane's capture shift register.
//   clr       : synchronous clear (wins over shift_en)
//   shift_en  : take din this cycle
//   lsb_first : 1 = din lands at bit_idx, 0 = shift left with din into bit 0
//   word_nxt  : word including this cycle's bit, so the parent can latch
//               a completed word in the same cycle as the last strobe
module serial_lane_shift #(
  parameter int BUF_SIZE = 8,
  parameter int CNT_W    = 4
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                shift_en,
  input  logic                lsb_first,
  input  logic [CNT_W-1:0]    bit_idx,
  input  logic                din,
  output logic [BUF_SIZE-1:0] word_nxt
);

  logic [BUF_SIZE-1:0] word_q;

  // Both orders stay right-aligned: the register is cleared at word start,
  // so bits at index >= count remain zero.
  always_comb begin
    word_nxt = word_q;
    if (shift_en) begin
      if (lsb_first) begin
        for (int i = 0; i < BUF_SIZE; i++) begin
          if (bit_idx == CNT_W'(i)) word_nxt[i] = din;
        end
      end else begin
        word_nxt = {word_q[BUF_SIZE-2:0], din};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)   word_q <= '0;
    else if (clr) word_q <= '0;
    else          word_q <= word_nxt;
  end

endmodule

// File: rtl/serial_multi_read_buffer.sv
// NUM_CH-lane serial-to-parallel capture buffer sharing one read strobe.
//   sys_clk, rst_n : clock, async active-low reset
//   bus (slave)    : start/stop/config in, read_sig + in_lines serial data,
//                    data_out/data_valid/data_ack word handshake,
//                    done_sig (high when idle), sticky overrun
// Single-shot mode returns to IDLE after a word; continuous mode re-arms
// in the completion cycle so a strobe on the very next cycle is not lost.
module serial_multi_read_buffer
  import serial_multi_read_buffer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int BUF_SIZE = 8,
  parameter int CNT_W    = cnt_width(BUF_SIZE)
) (
  input logic                      sys_clk,
  input logic                      rst_n,
  serial_multi_read_buffer_if.slave bus
);

  logic [0:0]                       state;
  logic [CNT_W-1:0]                 bit_cnt, cnt_lim, cnt_inc, rc_clamp;
  logic                             cont_q, lsb_q;
  logic                             valid_q, ovr_q;
  logic [NUM_CH-1:0][BUF_SIZE-1:0]  lane_nxt, word_q;
  logic                             take_start, take_stop, take_bit, word_done, lane_clr;

  assign rc_clamp   = (bus.read_count > CNT_W'(BUF_SIZE)) ? CNT_W'(BUF_SIZE) : bus.read_count;
  assign take_start = (state == ST_IDLE) && bus.start && (bus.read_count != '0);
  assign take_stop  = (state == ST_READ) && bus.stop;
  // stop beats a coincident strobe, including the completing one
  assign take_bit   = (state == ST_READ) && bus.read_sig && !bus.stop;
  assign cnt_inc    = bit_cnt + 1'b1;
  assign word_done  = take_bit && (cnt_inc == cnt_lim);
  assign lane_clr   = take_start || take_stop || word_done;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    serial_lane_shift #(
      .BUF_SIZE (BUF_SIZE),
      .CNT_W    (CNT_W)
    ) u_lane (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .clr       (lane_clr),
      .shift_en  (take_bit),
      .lsb_first (lsb_q),
      .bit_idx   (bit_cnt),
      .din       (bus.in_lines[k]),
      .word_nxt  (lane_nxt[k])
    );
  end

  // Control FSM and bit counter
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      cnt_lim <= '0;
      cont_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_start) begin
            state   <= ST_READ;
            bit_cnt <= '0;
            cnt_lim <= rc_clamp;
            cont_q  <= bus.cont_mode;
            lsb_q   <= bus.lsb_first;
          end
        end
        ST_READ: begin
          if (take_stop) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (word_done) begin
            bit_cnt <= '0;
            if (!cont_q) state <= ST_IDLE;
          end else if (take_bit) begin
            bit_cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word handshake: a completion outranks a coincident ack
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (word_done) begin
      word_q  <= lane_nxt;
      valid_q <= 1'b1;
      if (valid_q && !bus.data_ack) ovr_q <= 1'b1;
    end else begin
      if (take_start)   ovr_q   <= 1'b0;
      if (bus.data_ack) valid_q <= 1'b0;
    end
  end

  assign bus.data_out   = word_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.done_sig   = (state == ST_IDLE);

endmodule

// File: tb/tb_serial_multi_read_buffer.sv
module tb_serial_multi_read_buffer;

  localparam int NUM_CH   = 2;
  localparam int BUF_SIZE = 8;
  localparam int CNT_W    = 4;

  logic sys_clk = 1'b0;
  logic rst_n;
  always #5 sys_clk = ~sys_clk;

  serial_multi_read_buffer_if #(.NUM_CH(NUM_CH), .BUF_SIZE(BUF_SIZE), .CNT_W(CNT_W)) bus ();

  serial_multi_read_buffer #(.NUM_CH(NUM_CH), .BUF_SIZE(BUF_SIZE), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        ovr;
    logic        done;
  } exp_t;

  typedef struct {
    logic [3:0]  rc;
    int          nstb;
    logic        lsb;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [15:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start = 0; bus.stop = 0; bus.cont_mode = 0; bus.lsb_first = 0;
    bus.read_count = '0; bus.read_sig = 0; bus.in_lines = '0; bus.data_ack = 0;
  endtask

  function automatic logic bitsel(input logic [7:0] w, input int i, input int nb, input logic lsb);
    return lsb ? w[i] : w[nb-1-i];
  endfunction

  // read_sig is raised with junk data in the start cycle; it must not count
  task automatic do_start(input logic [3:0] rc, input logic cont, input logic lsb);
    bus.start = 1; bus.read_count = rc; bus.cont_mode = cont; bus.lsb_first = lsb;
    bus.read_sig = 1; bus.in_lines = 2'($urandom_range(3));
    step();
    bus.start = 0; bus.read_sig = 0;
  endtask

  task automatic strobe(input logic [1:0] lines, input logic gap);
    if (gap) begin
      bus.read_sig = 0; bus.in_lines = 2'($urandom_range(3));
      step();
    end
    bus.read_sig = 1; bus.in_lines = lines;
    step();
    bus.read_sig = 0;
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input int nb,
                           input logic lsb, input logic gaps);
    for (int i = 0; i < nb; i++)
      strobe({bitsel(w1, i, nb, lsb), bitsel(w0, i, nb, lsb)}, gaps && (i % 2 == 1));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_data"},  bus.data_out,   e.data);
    chk({tag, "_valid"}, bus.data_valid, e.valid);
    chk({tag, "_ovr"},   bus.overrun,    e.ovr);
    chk({tag, "_done"},  bus.done_sig,   e.done);
  endtask

  task automatic ack();
    bus.data_ack = 1;
    step();
    bus.data_ack = 0;
  endtask

  initial begin
    logic [7:0] a, b;
    int j;

    idle_in();
    rst_n = 0;
    step(); step();
    chk("rst_data",  bus.data_out,   16'h0);
    chk("rst_valid", bus.data_valid, 1'b0);
    chk("rst_ovr",   bus.overrun,    1'b0);
    chk("rst_done",  bus.done_sig,   1'b1);
    rst_n = 1;
    step();

    // rc, strobes, lsb, lane0 word, lane1 word, expected data_out
    vecs[0] = '{4'd8,  8, 1'b0, 8'h3A, 8'hC5, 16'hC53A};
    vecs[1] = '{4'd6,  6, 1'b1, 8'h2A, 8'h15, 16'h152A};
    vecs[2] = '{4'd15, 8, 1'b0, 8'hA5, 8'h5A, 16'h5AA5};
    vecs[3] = '{4'd3,  3, 1'b0, 8'hFD, 8'h02, 16'h0205};
    vecs[4] = '{4'd8,  8, 1'b1, 8'h81, 8'h7E, 16'h7E81};
    vecs[5] = '{4'd1,  1, 1'b1, 8'h01, 8'h00, 16'h0001};

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].rc, 1'b0, vecs[v].lsb);
      chk($sformatf("v%0d_busy", v), bus.done_sig, 1'b0);
      send_word(vecs[v].w0, vecs[v].w1, vecs[v].nstb, vecs[v].lsb, 1'(v % 2));
      sb.push_back('{vecs[v].exp_data, 1'b1, 1'b0, 1'b1});
      pop_check($sformatf("v%0d", v));
      ack();
      chk($sformatf("v%0d_ack", v), bus.data_valid, 1'b0);
    end

    // continuous mode, back-to-back strobes, ack between words
    do_start(4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? 8'h0F : 8'h09;
      b = (i < 4) ? 8'h03 : 8'h0C;
      j = i % 4;
      bus.data_ack = (i == 4);
      strobe({bitsel(b, j, 4, 1'b0), bitsel(a, j, 4, 1'b0)}, 1'b0);
      if (i == 3) begin sb.push_back('{16'h030F, 1'b1, 1'b0, 1'b0}); pop_check("cont_w1"); end
      if (i == 7) begin sb.push_back('{16'h0C09, 1'b1, 1'b0, 1'b0}); pop_check("cont_w2"); end
    end
    bus.data_ack = 0;
    bus.stop = 1; step(); bus.stop = 0;
    chk("cont_stop_done",  bus.done_sig,   1'b1);
    chk("cont_stop_valid", bus.data_valid, 1'b1);
    ack();

    // overrun: continuous, never acked
    do_start(4'd4, 1'b1, 1'b0);
    send_word(8'h06, 8'h01, 4, 1'b0, 1'b0);
    sb.push_back('{16'h0106, 1'b1, 1'b0, 1'b0}); pop_check("ovr_w1");
    send_word(8'h0B, 8'h0E, 4, 1'b0, 1'b0);
    sb.push_back('{16'h0E0B, 1'b1, 1'b1, 1'b0}); pop_check("ovr_w2");
    bus.stop = 1; step(); bus.stop = 0;
    chk("ovr_sticky", bus.overrun, 1'b1);
    do_start(4'd2, 1'b0, 1'b0);
    chk("start_clr_ovr",  bus.overrun,    1'b0);
    chk("start_keep_vld", bus.data_valid, 1'b1);
    // ack coincident with completion: new word, no overrun
    strobe(2'b01, 1'b0);
    bus.data_ack = 1;
    strobe(2'b10, 1'b0);
    bus.data_ack = 0;
    sb.push_back('{16'h0102, 1'b1, 1'b0, 1'b1}); pop_check("ack_same");

    // abort after 3 of 6 bits, stop coincident with a strobe
    do_start(4'd6, 1'b0, 1'b0);
    send_word(8'h07, 8'h07, 3, 1'b0, 1'b0);
    bus.stop = 1; bus.read_sig = 1; bus.in_lines = 2'b11;
    step();
    bus.stop = 0; bus.read_sig = 0;
    chk("abort_done",  bus.done_sig,   1'b1);
    chk("abort_valid", bus.data_valid, 1'b1);
    chk("abort_data",  bus.data_out,   16'h0102);
    // stop coincident with the completing strobe
    do_start(4'd2, 1'b0, 1'b0);
    strobe(2'b11, 1'b0);
    bus.stop = 1; bus.read_sig = 1; bus.in_lines = 2'b11;
    step();
    bus.stop = 0; bus.read_sig = 0;
    chk("stopdone_done", bus.done_sig, 1'b1);
    chk("stopdone_data", bus.data_out, 16'h0102);
    ack();

    // read_count = 0 is ignored
    bus.start = 1; bus.read_count = 4'd0; step(); bus.start = 0;
    chk("rc0_idle", bus.done_sig, 1'b1);
    send_word(8'h03, 8'h03, 2, 1'b0, 1'b0);
    chk("rc0_novalid", bus.data_valid, 1'b0);

    // start+stop in IDLE: start wins; a later start in READ is ignored
    bus.start = 1; bus.stop = 1; bus.read_count = 4'd2; bus.lsb_first = 0;
    step();
    bus.start = 0; bus.stop = 0;
    chk("startstop_busy", bus.done_sig, 1'b0);
    bus.start = 1; bus.read_count = 4'd8; bus.lsb_first = 1; step(); bus.start = 0;
    send_word(8'h01, 8'h02, 2, 1'b0, 1'b0);
    sb.push_back('{16'h0201, 1'b1, 1'b0, 1'b1}); pop_check("start_in_read");

    // async reset mid-word
    do_start(4'd6, 1'b0, 1'b0);
    send_word(8'h05, 8'h05, 3, 1'b0, 1'b0);
    rst_n = 0;
    #1;
    chk("mrst_data",  bus.data_out,   16'h0);
    chk("mrst_valid", bus.data_valid, 1'b0);
    chk("mrst_ovr",   bus.overrun,    1'b0);
    chk("mrst_done",  bus.done_sig,   1'b1);
    step();
    rst_n = 1;
    step();
    send_word(8'h3F, 8'h3F, 6, 1'b0, 1'b0);
    chk("mrst_no_rearm_done",  bus.done_sig,   1'b1);
    chk("mrst_no_rearm_valid", bus.data_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_multi_read_buffer.md
Name: serial_multi_read_buffer

Overview:
NUM_CH-lane serial-to-parallel capture buffer sharing one synchronous read strobe. It is the successor of the single-lane serial read buffer and targets quad/dual-line SPI and parallel sniffed buses in the MITM datapath.
- Additions over the single-lane buffer: per-lane shift registers, runtime bit order, continuous (streaming) mode with valid/ack handshake and sticky overrun, and an abort input.
- Sits between the EdgeDetector-generated read_sig and the interceptor FSMs.

Parameters:
NUM_CH, 2, number of parallel serial input lanes
BUF_SIZE, 8, maximum word length per lane in bits
CNT_W, $clog2(BUF_SIZE+1), width of read_count

Ports:
sys_clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  1-cycle pulse; begin capture (honoured only in IDLE)
stop  in  1  1-cycle pulse; abort capture (honoured only in READ)
cont_mode  in  1  sampled at start; 1 = re-arm automatically after each word
lsb_first  in  1  sampled at start; 1 = first received bit is bit 0
read_count  in  CNT_W  sampled at start; bits per word
read_sig  in  1  1-cycle sample strobe, synchronous to sys_clk
in_lines  in  NUM_CH  serial data, lane k on bit k
data_out  out  NUM_CH*BUF_SIZE  lane k word at [k*BUF_SIZE +: BUF_SIZE]
data_valid  out  1  word held in data_out, cleared by data_ack
data_ack  in  1  consumer acknowledge
done_sig  out  1  high in IDLE, low in READ
overrun  out  1  sticky; a word completed while data_valid was still high

Behaviour:
- Reset (async assert, sync release): state IDLE; data_out=0; data_valid=0; overrun=0; done_sig=1; internal counter, shift registers and latched config cleared.
- States: IDLE, READ.
- IDLE + start:
  - read_count=0: ignored, stay IDLE.
  - read_count>BUF_SIZE: clamped to BUF_SIZE.
  - Otherwise latch count, cont_mode and lsb_first; clear shift registers, bit counter and overrun; go to READ. done_sig drops the next cycle.
  - read_sig in the start cycle is not sampled.
- READ + read_sig: each lane samples in_lines[k] and the bit counter increments.
  - MSB-first: shift left, new bit into bit 0.
  - LSB-first: bit i written at index i.
  - Either way the word is right-aligned; bits at index >= count are 0.
- Word completion (counter reaches count on a read_sig in cycle n):
  - At n+1: data_out updated for all lanes and data_valid=1.
  - If data_valid was already 1 and not acked in cycle n: overrun set; data_out is overwritten.
  - cont_mode=0: return to IDLE; done_sig=1 at n+1.
  - cont_mode=1: stay in READ with counter and shift registers cleared. A read_sig at n+1 is bit 0 of the next word, so no strobes are lost.
- data_ack with data_valid=1 clears data_valid next cycle.
  - Ack in the same cycle as a completion: the new word wins, data_valid stays 1, no overrun.
- stop in READ: partial word discarded; data_out, data_valid and overrun untouched; IDLE next cycle.
  - stop and read_sig in the same cycle: stop wins, bit dropped.
  - stop and completion in the same cycle: stop wins, no word delivered.
- start while in READ and stop while in IDLE are ignored. start and stop in the same IDLE cycle: start honoured.
- rst_n low mid-capture: immediate return to reset values; next capture needs a fresh start.
- Counter width CNT_W; no wrap, because it is cleared at every completion, start and stop.

Decomposition:
- Shared package/header: state encodings (ST_IDLE, ST_READ) and the CNT_W derivation.
- Natural sub-module: serial_lane_shift (one lane's shift register with MSB/LSB insert, width BUF_SIZE), instantiated NUM_CH times by generate.
- Counter, FSM and handshake stay in the top.

Test Plan:
- Single word: NUM_CH=2, count=8, MSB-first; lane0 sends 0x3A, lane1 sends 0xC5 -> data_out={0xC5,0x3A}, data_valid=1 and done_sig=1 one cycle after the 8th read_sig.
- Short LSB-first: count=6, lsb_first=1, lane0 serial sequence 0,1,0,1,0,1 -> lane0=6'b101010=0x2A, bits 7:6=0.
- Continuous mode with ack: cont_mode=1, count=4, back-to-back read_sig; lane0 sends 0xF then 0x9, acked between words -> two valid words 0xF and 0x9, overrun=0, done_sig stays 0.
- Overrun: cont_mode=1, count=4, no ack -> after the 2nd word overrun=1 and data_out holds the 2nd word. A subsequent start clears overrun.
- Abort and reset mid-word: stop after 3 of 6 bits -> IDLE, data_valid unchanged. Repeat with rst_n low after 3 bits -> all outputs at reset values, done_sig=1.
- Boundaries:
  - read_count=0 -> remains IDLE.
  - read_count=15 with BUF_SIZE=8 -> completes after 8 strobes.
  - read_sig in the start cycle -> not counted.
